// File: rtl/picobello_pkg.sv
// Shared memory-tile geometry constants and helpers that derive the
// banked SRAM dimensions from a word width and macro depth.
package picobello_pkg;

    localparam int unsigned MemTileSramDataWidth = 64;
    localparam int unsigned MemTileSramNumWords  = 2048;
    localparam int unsigned MemTileNumBankRows   = 4;

    function automatic int unsigned num_banks_per_word(input int unsigned data_width,
                                                       input int unsigned sram_data_width);
        return data_width / sram_data_width;
    endfunction

    function automatic int unsigned sram_addr_width(input int unsigned num_words);
        return $clog2(num_words);
    endfunction

    // A single row still needs a one-bit select so the decode stays uniform.
    function automatic int unsigned sel_width(input int unsigned num_rows);
        return (num_rows > 1) ? $clog2(num_rows) : 1;
    endfunction

endpackage

// File: rtl/mem_bank_rsp_fifo.sv
// Generic fall-through FIFO with synchronous reset: a push into an empty
// FIFO is visible on data_o in the same cycle and can be popped at once.
module mem_bank_rsp_fifo #(
    parameter int unsigned Depth = 2,
    parameter type         T     = logic
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntWidth = $clog2(Depth + 1);

    T                    mem_q [Depth];
    T                    mem_d [Depth];
    logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0] count_q, count_d;
    logic                stored_empty;
    logic                bypass;
    logic                do_write;
    logic                do_read;

    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] ptr);
        return (ptr == PtrWidth'(Depth - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign stored_empty = (count_q == '0);
    assign full_o       = (count_q == CntWidth'(Depth));
    assign empty_o      = stored_empty & ~push_i;
    assign data_o       = stored_empty ? (push_i ? data_i : '0) : mem_q[rd_ptr_q];

    // An entry pushed and popped in the same cycle while empty never gets stored.
    assign bypass   = stored_empty & push_i & pop_i;
    assign do_write = push_i & ~bypass & (~full_o | pop_i);
    assign do_read  = pop_i & ~stored_empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_write) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (do_read) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({do_write, do_read})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/mem_bank_ctrl.sv
// OBI subordinate for the memory tile: decodes requests onto rows of banked
// latency-1 SRAM macros and buffers responses so rready never loses data.
module mem_bank_ctrl
    import picobello_pkg::*;
#(
    parameter int unsigned AddrWidth     = 48,
    parameter int unsigned DataWidth     = 512,
    parameter int unsigned IdWidth       = 4,
    parameter int unsigned SramDataWidth = MemTileSramDataWidth,
    parameter int unsigned SramNumWords  = MemTileSramNumWords,
    parameter int unsigned NumBankRows   = MemTileNumBankRows,
    parameter int unsigned RspDepth      = 2,
    localparam int unsigned SramAddrWidth = sram_addr_width(SramNumWords)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            obi_req_i,
    output logic                            obi_gnt_o,
    input  logic [AddrWidth-1:0]            obi_addr_i,
    input  logic                            obi_we_i,
    input  logic [DataWidth/8-1:0]          obi_be_i,
    input  logic [DataWidth-1:0]            obi_wdata_i,
    input  logic [IdWidth-1:0]              obi_aid_i,
    output logic                            obi_rvalid_o,
    input  logic                            obi_rready_i,
    output logic [DataWidth-1:0]            obi_rdata_o,
    output logic [IdWidth-1:0]              obi_rid_o,
    output logic                            obi_err_o,
    output logic [NumBankRows-1:0]          sram_req_o,
    output logic                            sram_we_o,
    output logic [SramAddrWidth-1:0]        sram_addr_o,
    output logic [DataWidth-1:0]            sram_wdata_o,
    output logic [DataWidth/8-1:0]          sram_be_o,
    input  logic [NumBankRows*DataWidth-1:0] sram_rdata_i
);

    localparam int unsigned NumBanksPerWord = num_banks_per_word(DataWidth, SramDataWidth);
    localparam int unsigned SelWidth        = sel_width(NumBankRows);
    localparam int unsigned ByteOff         = $clog2(DataWidth / 8);
    localparam int unsigned SelLsb          = ByteOff + SramAddrWidth;
    localparam int unsigned UpperLsb        = SelLsb + SelWidth;
    localparam int unsigned CntWidth        = $clog2(RspDepth + 1);

    typedef struct packed {
        logic [DataWidth-1:0] rdata;
        logic [IdWidth-1:0]   rid;
        logic                 err;
    } rsp_t;

    logic [SelWidth-1:0]  sel;
    logic                 sel_ok;
    logic                 upper_set;
    logic                 in_range;
    logic                 accept;
    logic                 pop;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic                 stage_valid_q, stage_valid_d;
    logic                 stage_we_q, stage_we_d;
    logic                 stage_err_q, stage_err_d;
    logic [IdWidth-1:0]   stage_id_q, stage_id_d;
    logic [SelWidth-1:0]  stage_sel_q, stage_sel_d;
    logic [DataWidth-1:0] row_rdata;
    rsp_t                 stage_rsp;
    rsp_t                 fifo_rsp;
    logic                 fifo_push;
    logic                 fifo_empty;
    logic                 fifo_full_unused;
    logic                 addr_lsb_unused;

    assign addr_lsb_unused = ^obi_addr_i[ByteOff-1:0];

    assign sel       = obi_addr_i[SelLsb +: SelWidth];
    assign upper_set = |obi_addr_i[AddrWidth-1:UpperLsb];

    // Only a non-power-of-two row count can produce an unused select code.
    if ((2 ** SelWidth) > NumBankRows) begin : gen_sel_check
        assign sel_ok = (32'(sel) < NumBankRows);
    end else begin : gen_sel_full
        assign sel_ok = 1'b1;
    end

    assign in_range = sel_ok & ~upper_set;

    // The grant depends only on the registered credit count, never on rready.
    assign obi_gnt_o = obi_req_i & (cnt_q < CntWidth'(RspDepth)) & ~rst_i;
    assign accept    = obi_req_i & obi_gnt_o;

    always_comb begin
        sram_req_o = '0;
        for (int unsigned r = 0; r < NumBankRows; r++) begin
            if (accept && in_range && (sel == SelWidth'(r))) begin
                sram_req_o[r] = 1'b1;
            end
        end
    end

    assign sram_we_o   = accept & obi_we_i;
    assign sram_addr_o = obi_addr_i[ByteOff +: SramAddrWidth];
    assign sram_be_o   = obi_be_i;

    for (genvar b = 0; b < NumBanksPerWord; b++) begin : gen_bank_wdata
        assign sram_wdata_o[b*SramDataWidth +: SramDataWidth] =
            obi_wdata_i[b*SramDataWidth +: SramDataWidth];
    end

    always_comb begin
        stage_valid_d = accept;
        stage_we_d    = obi_we_i;
        stage_err_d   = ~in_range;
        stage_id_d    = obi_aid_i;
        stage_sel_d   = sel;
        cnt_d         = cnt_q;
        case ({accept, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        row_rdata = '0;
        for (int unsigned r = 0; r < NumBankRows; r++) begin
            if (stage_sel_q == SelWidth'(r)) begin
                row_rdata = sram_rdata_i[r*DataWidth +: DataWidth];
            end
        end
        stage_rsp.rdata = (stage_we_q || stage_err_q) ? '0 : row_rdata;
        stage_rsp.rid   = stage_id_q;
        stage_rsp.err   = stage_err_q;
    end

    assign fifo_push = stage_valid_q & ~rst_i;

    mem_bank_rsp_fifo #(
        .Depth (RspDepth),
        .T     (rsp_t)
    ) i_rsp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .data_i  (stage_rsp),
        .pop_i   (pop),
        .data_o  (fifo_rsp),
        .full_o  (fifo_full_unused),
        .empty_o (fifo_empty)
    );

    assign obi_rvalid_o = ~fifo_empty & ~rst_i;
    assign pop          = obi_rvalid_o & obi_rready_i;
    assign obi_rdata_o  = obi_rvalid_o ? fifo_rsp.rdata : '0;
    assign obi_rid_o    = obi_rvalid_o ? fifo_rsp.rid : '0;
    assign obi_err_o    = obi_rvalid_o & fifo_rsp.err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q         <= '0;
            stage_valid_q <= 1'b0;
            stage_we_q    <= 1'b0;
            stage_err_q   <= 1'b0;
            stage_id_q    <= '0;
            stage_sel_q   <= '0;
        end else begin
            cnt_q         <= cnt_d;
            stage_valid_q <= stage_valid_d;
            stage_we_q    <= stage_we_d;
            stage_err_q   <= stage_err_d;
            stage_id_q    <= stage_id_d;
            stage_sel_q   <= stage_sel_d;
        end
    end

endmodule

// File: tb/tb_mem_bank_ctrl.sv
// Directed bench for mem_bank_ctrl: a flat-memory reference model with a
// response queue checks the outputs every cycle, plus literal spot checks.
module tb_mem_bank_ctrl;

    localparam int DEPTH = 2;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          obi_req_i;
    logic          obi_gnt_o;
    logic [47:0]   obi_addr_i;
    logic          obi_we_i;
    logic [63:0]   obi_be_i;
    logic [511:0]  obi_wdata_i;
    logic [3:0]    obi_aid_i;
    logic          obi_rvalid_o;
    logic          obi_rready_i;
    logic [511:0]  obi_rdata_o;
    logic [3:0]    obi_rid_o;
    logic          obi_err_o;
    logic [3:0]    sram_req_o;
    logic          sram_we_o;
    logic [10:0]   sram_addr_o;
    logic [511:0]  sram_wdata_o;
    logic [63:0]   sram_be_o;
    logic [2047:0] sram_rdata_i = '0;

    int unsigned cycle_count = 0;
    int          pass_count  = 0;
    int          check_count = 0;
    bit          model_on    = 1'b0;

    mem_bank_ctrl dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .obi_req_i    (obi_req_i),
        .obi_gnt_o    (obi_gnt_o),
        .obi_addr_i   (obi_addr_i),
        .obi_we_i     (obi_we_i),
        .obi_be_i     (obi_be_i),
        .obi_wdata_i  (obi_wdata_i),
        .obi_aid_i    (obi_aid_i),
        .obi_rvalid_o (obi_rvalid_o),
        .obi_rready_i (obi_rready_i),
        .obi_rdata_o  (obi_rdata_o),
        .obi_rid_o    (obi_rid_o),
        .obi_err_o    (obi_err_o),
        .sram_req_o   (sram_req_o),
        .sram_we_o    (sram_we_o),
        .sram_addr_o  (sram_addr_o),
        .sram_wdata_o (sram_wdata_o),
        .sram_be_o    (sram_be_o),
        .sram_rdata_i (sram_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cycle_count <= cycle_count + 1;

    task automatic checkOutput(input string name, input logic [511:0] actual,
                               input logic [511:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic req, input logic we, input logic [47:0] addr,
                                 input logic [63:0] be, input logic [511:0] wdata,
                                 input logic [3:0] aid, input logic rready);
        obi_req_i    = req;
        obi_we_i     = we;
        obi_addr_i   = addr;
        obi_be_i     = be;
        obi_wdata_i  = wdata;
        obi_aid_i    = aid;
        obi_rready_i = rready;
    endtask

    task automatic advance();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input logic rready);
        applyStimulus(1'b0, 1'b0, 48'h0, 64'h0, 512'h0, 4'h0, rready);
    endtask

    // Environment: four rows of latency-1 SRAM, each a sparse store of words.
    logic [511:0] sram_store [int];
    always @(posedge clk_i) begin
        for (int r = 0; r < 4; r++) begin
            int           key;
            logic [511:0] word;
            if (sram_req_o[r]) begin
                key  = r * 2048 + int'(sram_addr_o);
                word = sram_store.exists(key) ? sram_store[key] : '0;
                if (sram_we_o) begin
                    for (int b = 0; b < 64; b++)
                        if (sram_be_o[b]) word[b*8 +: 8] = sram_wdata_o[b*8 +: 8];
                    sram_store[key] = word;
                end else begin
                    sram_rdata_i[r*512 +: 512] <= word;
                end
            end
        end
    end

    // Reference model: a flat byte-addressed memory of 512 KiB (4 rows x 2048
    // words x 64 bytes) and an in-order queue of owed responses.
    typedef struct {
        logic [511:0] rdata;
        logic [3:0]   rid;
        logic         err;
        int unsigned  cyc;
    } exp_t;

    exp_t         exp_q [$];
    logic [511:0] ref_mem [longint];

    always @(negedge clk_i) begin
        logic         exp_gnt;
        logic         exp_rvalid;
        logic         in_range;
        logic [3:0]   exp_req;
        longint       row;
        longint       word_idx;
        logic [511:0] w;
        exp_t         e;
        if (model_on) begin
            in_range   = (obi_addr_i < 48'h80000);
            row        = longint'(obi_addr_i / 48'h20000);
            word_idx   = longint'(obi_addr_i / 48'd64);
            exp_gnt    = obi_req_i && (exp_q.size() < DEPTH) && !rst_i;
            exp_rvalid = !rst_i && (exp_q.size() > 0) && (exp_q[0].cyc < cycle_count);
            exp_req    = (exp_gnt && in_range) ? (4'b0001 << row) : 4'b0000;

            checkOutput("model_gnt", obi_gnt_o, exp_gnt);
            checkOutput("model_rvalid", obi_rvalid_o, exp_rvalid);
            checkOutput("model_sram_req", sram_req_o, exp_req);
            checkOutput("model_sram_we", sram_we_o, exp_gnt && obi_we_i);
            if (exp_gnt && in_range) begin
                checkOutput("model_sram_addr", sram_addr_o, word_idx % 2048);
                checkOutput("model_sram_be", sram_be_o, obi_be_i);
                checkOutput("model_sram_wdata", sram_wdata_o, obi_wdata_i);
            end
            if (exp_rvalid) begin
                checkOutput("model_rdata", obi_rdata_o, exp_q[0].rdata);
                checkOutput("model_rid", obi_rid_o, exp_q[0].rid);
                checkOutput("model_err", obi_err_o, exp_q[0].err);
            end else if (!rst_i) begin
                checkOutput("model_idle_rsp", {obi_rdata_o[506:0], obi_rid_o, obi_err_o}, '0);
            end

            if (rst_i) begin
                exp_q.delete();
            end else begin
                if (exp_rvalid && obi_rready_i) void'(exp_q.pop_front());
                if (exp_gnt) begin
                    e.rid   = obi_aid_i;
                    e.cyc   = cycle_count;
                    e.err   = !in_range;
                    e.rdata = '0;
                    if (in_range) begin
                        w = ref_mem.exists(word_idx) ? ref_mem[word_idx] : '0;
                        if (obi_we_i) begin
                            for (int b = 0; b < 64; b++)
                                if (obi_be_i[b]) w[b*8 +: 8] = obi_wdata_i[b*8 +: 8];
                            ref_mem[word_idx] = w;
                        end else begin
                            e.rdata = w;
                        end
                    end
                    exp_q.push_back(e);
                end
            end
        end
    end

    initial begin
        logic [47:0]  addr;
        logic [511:0] data;

        rst_i = 1'b1;
        applyStimulus(1'b1, 1'b0, 48'h20040, '1, '0, 4'h0, 1'b0);
        advance();
        model_on = 1'b1;
        @(negedge clk_i);
        checkOutput("reset_gnt", obi_gnt_o, 1'b0);
        checkOutput("reset_rvalid", obi_rvalid_o, 1'b0);
        checkOutput("reset_sram_req", sram_req_o, 4'b0000);
        checkOutput("reset_sram_we", sram_we_o, 1'b0);
        checkOutput("reset_rdata", obi_rdata_o, '0);
        checkOutput("reset_rid_err", {obi_rid_o, obi_err_o}, 5'b0);
        advance();
        rst_i = 1'b0;
        idle(1'b1);
        advance();

        // Preload rows 0 and 3, words 0 and 1.
        for (int i = 0; i < 4; i++) begin
            addr = ((i < 2) ? 48'h0 : 48'h60000) + 48'(((i % 2) * 64));
            data = {16{32'hC0DE_0000 + 32'(i)}};
            applyStimulus(1'b1, 1'b1, addr, '1, data, 4'(i), 1'b1);
            advance();
        end
        idle(1'b1);
        advance();
        advance();

        // Write then read back sel 1, sram word 1.
        applyStimulus(1'b1, 1'b1, 48'h20040, '1, {64{8'hA5}}, 4'h1, 1'b1);
        @(negedge clk_i);
        checkOutput("wr_gnt", obi_gnt_o, 1'b1);
        checkOutput("wr_sram_req", sram_req_o, 4'b0010);
        checkOutput("wr_sram_addr", sram_addr_o, 11'd1);
        checkOutput("wr_sram_we", sram_we_o, 1'b1);
        advance();
        applyStimulus(1'b1, 1'b0, 48'h20040, '0, '0, 4'h2, 1'b1);
        @(negedge clk_i);
        checkOutput("wr_rsp_valid", obi_rvalid_o, 1'b1);
        checkOutput("wr_rsp_rdata", obi_rdata_o, '0);
        checkOutput("wr_rsp_rid_err", {obi_rid_o, obi_err_o}, {4'h1, 1'b0});
        advance();
        idle(1'b1);
        @(negedge clk_i);
        checkOutput("rd_rsp_valid", obi_rvalid_o, 1'b1);
        checkOutput("rd_rsp_rdata", obi_rdata_o, {64{8'hA5}});
        checkOutput("rd_rsp_rid_err", {obi_rid_o, obi_err_o}, {4'h2, 1'b0});
        advance();

        // Out-of-range read.
        applyStimulus(1'b1, 1'b0, 48'h80000, '0, '0, 4'h3, 1'b1);
        @(negedge clk_i);
        checkOutput("oor_gnt", obi_gnt_o, 1'b1);
        checkOutput("oor_sram_req", sram_req_o, 4'b0000);
        advance();
        idle(1'b1);
        @(negedge clk_i);
        checkOutput("oor_rsp_valid", obi_rvalid_o, 1'b1);
        checkOutput("oor_rsp_rid_err", {obi_rid_o, obi_err_o}, {4'h3, 1'b1});
        checkOutput("oor_rsp_rdata", obi_rdata_o, '0);
        advance();

        // Backpressure: credits run out after two grants.
        applyStimulus(1'b1, 1'b0, 48'h0, '0, '0, 4'h5, 1'b0);
        @(negedge clk_i);
        checkOutput("bp_gnt0", obi_gnt_o, 1'b1);
        advance();
        applyStimulus(1'b1, 1'b0, 48'h40, '0, '0, 4'h6, 1'b0);
        @(negedge clk_i);
        checkOutput("bp_gnt1", obi_gnt_o, 1'b1);
        advance();
        applyStimulus(1'b1, 1'b0, 48'h60000, '0, '0, 4'h7, 1'b0);
        @(negedge clk_i);
        checkOutput("bp_gnt2_blocked", obi_gnt_o, 1'b0);
        checkOutput("bp_hold_rid", obi_rid_o, 4'h5);
        checkOutput("bp_hold_rdata", obi_rdata_o, {16{32'hC0DE_0000}});
        advance();
        obi_rready_i = 1'b1;
        @(negedge clk_i);
        checkOutput("bp_gnt_during_pop", obi_gnt_o, 1'b0);
        advance();
        @(negedge clk_i);
        checkOutput("bp_gnt_after_pop", obi_gnt_o, 1'b1);
        checkOutput("bp_second_rid", obi_rid_o, 4'h6);
        checkOutput("bp_second_rdata", obi_rdata_o, {16{32'hC0DE_0001}});
        advance();
        idle(1'b1);
        @(negedge clk_i);
        checkOutput("bp_third_rid", obi_rid_o, 4'h7);
        checkOutput("bp_third_rdata", obi_rdata_o, {16{32'hC0DE_0002}});
        advance();

        // Back-to-back reads alternating rows 0 and 3.
        for (int i = 0; i < 16; i++) begin
            addr = ((i % 2) != 0 ? 48'h60000 : 48'h0) + 48'((((i / 2) % 2) * 64));
            applyStimulus(1'b1, 1'b0, addr, '0, '0, 4'(i), 1'b1);
            @(negedge clk_i);
            checkOutput("b2b_gnt", obi_gnt_o, 1'b1);
            if (i > 0) checkOutput("b2b_rsp_rid", {obi_rvalid_o, obi_rid_o}, {1'b1, 4'(i - 1)});
            advance();
        end
        idle(1'b1);
        @(negedge clk_i);
        checkOutput("b2b_last_rsp", {obi_rvalid_o, obi_rid_o}, {1'b1, 4'hF});
        advance();

        // Reset with two responses outstanding.
        applyStimulus(1'b1, 1'b0, 48'h0, '0, '0, 4'h8, 1'b0);
        advance();
        applyStimulus(1'b1, 1'b0, 48'h60040, '0, '0, 4'h9, 1'b0);
        advance();
        rst_i = 1'b1;
        applyStimulus(1'b1, 1'b0, 48'h0, '0, '0, 4'hA, 1'b0);
        @(negedge clk_i);
        checkOutput("rst_mid_rvalid", obi_rvalid_o, 1'b0);
        checkOutput("rst_mid_gnt", obi_gnt_o, 1'b0);
        checkOutput("rst_mid_sram_req", sram_req_o, 4'b0000);
        advance();
        rst_i = 1'b0;
        applyStimulus(1'b1, 1'b0, 48'h40, '0, '0, 4'hB, 1'b1);
        @(negedge clk_i);
        checkOutput("rst_after_gnt", obi_gnt_o, 1'b1);
        checkOutput("rst_after_no_stale", obi_rvalid_o, 1'b0);
        advance();
        idle(1'b1);
        @(negedge clk_i);
        checkOutput("rst_new_rsp", {obi_rvalid_o, obi_rid_o}, {1'b1, 4'hB});
        checkOutput("rst_new_rdata", obi_rdata_o, {16{32'hC0DE_0001}});
        advance();
        @(negedge clk_i);
        checkOutput("rst_drained", obi_rvalid_o, 1'b0);
        advance();

        // Partial write to row 2.
        applyStimulus(1'b1, 1'b1, 48'h40000, '1, {64{8'h11}}, 4'h1, 1'b1);
        advance();
        applyStimulus(1'b1, 1'b1, 48'h40000, 64'hF, {64{8'h22}}, 4'h2, 1'b1);
        advance();
        applyStimulus(1'b1, 1'b0, 48'h40000, '0, '0, 4'h3, 1'b1);
        advance();
        idle(1'b1);
        @(negedge clk_i);
        checkOutput("pw_rsp_rid", {obi_rvalid_o, obi_rid_o}, {1'b1, 4'h3});
        checkOutput("pw_rdata", obi_rdata_o, {{60{8'h11}}, {4{8'h22}}});
        advance();
        advance();
        advance();

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
